// File: rtl/seg7_bus_if.sv
// Store/readback bus between the write-select stage and the seven-segment controller.
// The write-select stage is the master and the display controller is the slave.
interface seg7_bus_if;
  localparam int unsigned DATA_W = 32;

  logic              seg_we;
  logic [DATA_W-1:0] seg_wdata;
  logic [DATA_W-1:0] seg_rdata;

  modport master (output seg_we, output seg_wdata, input seg_rdata);
  modport slave  (input seg_we, input seg_wdata, output seg_rdata);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit common-anode seven-segment scan controller for the display register at 0x1004.
// It holds the last stored word and time-multiplexes its hex nibbles onto the digits.
module seg7_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter bit          BLANK_LZ = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  seg7_bus_if.slave  bus,
  output logic [7:0] o_an,
  output logic [7:0] o_seg
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DIG_W  = 3;
  localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  scan_cnt;
  logic [DIG_W-1:0]  dig_idx;

  logic [4:0]        bit_base_c;
  logic [DATA_W-1:0] upper_c;
  logic [3:0]        nib_c;
  logic              blank_c;
  logic [7:0]        seg_c;
  logic [7:0]        an_c;

  // Active-low {g,f,e,d,c,b,a} glyphs for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] g;
    g = 7'h7F;
    unique case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // Held display value; the last sampled word wins on back-to-back stores
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (bus.seg_we) begin
      data_q <= bus.seg_wdata;
    end
  end

  assign bus.seg_rdata = data_q;

  // Dwell counter; the digit index advances on the wrap edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_cnt == CNT_MAX) begin
      scan_cnt <= '0;
      dig_idx  <= dig_idx + DIG_W'(1);
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  // Digit decode: a leading-zero digit is blanked only above digit 0
  always_comb begin
    bit_base_c = {dig_idx, 2'b00};
    upper_c    = data_q >> bit_base_c;
    nib_c      = data_q[bit_base_c +: 4];
    blank_c    = BLANK_LZ && (dig_idx != DIG_W'(0)) && (upper_c == '0);
    seg_c      = blank_c ? 8'hFF : {1'b1, hex7(nib_c)};
    an_c       = ~(8'b1 << dig_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_an  <= 8'hFF;
      o_seg <= 8'hFF;
    end else begin
      o_an  <= an_c;
      o_seg <= seg_c;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench: two controllers (leading-zero blanking off and on) share one stimulus stream.
// A cycle-count reference model and directed expectations are compared every cycle.
module tb_seg7_scan_ctrl;
  localparam int unsigned SCAN_DIV = 4;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] wdata;
  logic [7:0]  an_a, seg_a, an_b, seg_b;

  int checks = 0;
  int errors = 0;

  seg7_bus_if bus_a ();
  seg7_bus_if bus_b ();

  assign bus_a.seg_we    = we;
  assign bus_a.seg_wdata = wdata;
  assign bus_b.seg_we    = we;
  assign bus_b.seg_wdata = wdata;

  seg7_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .o_an(an_a), .o_seg(seg_a));
  seg7_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .o_an(an_b), .o_seg(seg_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counts edges since reset release and remembers the stored word
  int unsigned n;
  logic [31:0] mdata;
  logic [7:0]  exp_an, exp_seg_a, exp_seg_b;

  function automatic int dig_of(input int unsigned k);
    return int'((k / SCAN_DIV) % 8);
  endfunction

  function automatic logic [7:0] seg_exp(input logic [31:0] v, input int d, input bit lz);
    logic [31:0] up;
    up = v >> (4 * d);
    if (lz && d != 0 && up == 32'd0) return 8'hFF;
    return {1'b1, HEX[up[3:0]]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n         <= 0;
      mdata     <= '0;
      exp_an    <= 8'hFF;
      exp_seg_a <= 8'hFF;
      exp_seg_b <= 8'hFF;
    end else begin
      exp_an    <= ~(8'd1 << dig_of(n));
      exp_seg_a <= seg_exp(mdata, dig_of(n), 1'b0);
      exp_seg_b <= seg_exp(mdata, dig_of(n), 1'b1);
      n         <= n + 1;
      if (we) mdata <= wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("model_an_a", {24'd0, an_a}, {24'd0, exp_an});
    chk("model_an_b", {24'd0, an_b}, {24'd0, exp_an});
    chk("model_seg_a", {24'd0, seg_a}, {24'd0, exp_seg_a});
    chk("model_seg_b", {24'd0, seg_b}, {24'd0, exp_seg_b});
    chk("model_rdata_a", bus_a.seg_rdata, mdata);
    chk("model_rdata_b", bus_b.seg_rdata, mdata);
  endtask

  // Assert reset for one edge, then release with the given store pending on edge 1
  task automatic restart(input logic w, input logic [31:0] d);
    rst_n = 1'b0;
    we    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    we    = w;
    wdata = d;
  endtask

  initial begin
    logic [7:0] frame_a [8];
    logic [7:0] frame_b [8];
    int dig;

    rst_n = 1'b0;
    we    = 1'b0;
    wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", {24'd0, an_a}, 32'h0000_00FF);
    chk("rst_seg", {24'd0, seg_a}, 32'h0000_00FF);
    chk("rst_rdata", bus_a.seg_rdata, 32'h0);

    // Store 0x12345678 pending on the first edge after release
    rst_n = 1'b1;
    we    = 1'b1;
    wdata = 32'h1234_5678;
    tick();
    we = 1'b0;
    chk("release_an", {24'd0, an_a}, 32'h0000_00FE);
    chk("release_seg", {24'd0, seg_a}, 32'h0000_00C0);
    frame_a = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    for (int e = 2; e <= 36; e++) begin
      tick();
      dig = ((e - 1) / 4) % 8;
      chk("walk_an", {24'd0, an_a}, {24'd0, ~(8'd1 << dig)});
      chk("walk_seg", {24'd0, seg_a}, {24'd0, frame_a[dig]});
    end

    // Mid-scan store while digit 0 is lit: readback after 1 edge, glyph after 2
    restart(1'b1, 32'h0000_000F);
    tick();
    we = 1'b0;
    chk("lat_rdata", bus_a.seg_rdata, 32'h0000_000F);
    chk("lat_seg_pre", {24'd0, seg_a}, 32'h0000_00C0);
    tick();
    chk("lat_seg", {24'd0, seg_a}, 32'h0000_008E);
    chk("lat_an", {24'd0, an_a}, 32'h0000_00FE);

    // Leading-zero blanking on 0x00000A05
    restart(1'b1, 32'h0000_0A05);
    tick();
    we = 1'b0;
    frame_b = '{8'h92, 8'hC0, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int e = 2; e <= 32; e++) begin
      tick();
      dig = ((e - 1) / 4) % 8;
      chk("blank_an", {24'd0, an_b}, {24'd0, ~(8'd1 << dig)});
      chk("blank_seg", {24'd0, seg_b}, {24'd0, frame_b[dig]});
    end

    // Value 0 with blanking: only digit 0 shows a glyph
    restart(1'b1, 32'h0);
    tick();
    we = 1'b0;
    for (int e = 2; e <= 32; e++) begin
      tick();
      dig = ((e - 1) / 4) % 8;
      chk("zero_seg", {24'd0, seg_b}, (dig == 0) ? 32'h0000_00C0 : 32'h0000_00FF);
    end

    // Back-to-back stores: last word wins
    we = 1'b1;
    wdata = 32'hAAAA_0001;
    tick();
    wdata = 32'hBBBB_0002;
    tick();
    wdata = 32'hCCCC_0003;
    tick();
    we = 1'b0;
    chk("b2b_rdata", bus_a.seg_rdata, 32'hCCCC_0003);

    // Asynchronous reset while digit 5 is lit
    restart(1'b1, 32'h8765_4321);
    for (int e = 1; e <= 22; e++) begin
      tick();
      we = 1'b0;
    end
    chk("pre_async_an", {24'd0, an_a}, 32'h0000_00DF);
    rst_n = 1'b0;
    #1;
    chk("async_an", {24'd0, an_a}, 32'h0000_00FF);
    chk("async_seg", {24'd0, seg_a}, 32'h0000_00FF);
    chk("async_rdata", bus_a.seg_rdata, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("restart_an", {24'd0, an_a}, 32'h0000_00FE);

    // Randomized stores, including values with many leading zeros
    for (int i = 0; i < 400; i++) begin
      we    = ($urandom_range(0, 2) == 0);
      wdata = $urandom >> $urandom_range(0, 31);
      tick();
    end
    we = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
